pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Issue controller for the decode stage of the in-order pipeline.
- Holds a per-register scoreboard of in-flight writers and stalls ID→EX issue on RAW hazards and on writer-count saturation.
- Converts EX branch redirects into a front-end flush, and sequences ebreak: drain, then halt.
- Sits between the ID stage valid/ready handshake and the EX stage, and observes writeback.

Parameters:
- NUM_REGS, 32, architectural GPR count (16 for RV32E); index width = $clog2(NUM_REGS).
- CNT_W, 2, per-register pending-writer counter width; saturates at 2^CNT_W-1.
- INFL_W, 3, width of the total in-flight instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a decoded uop.
- id_rs1_i  in  IDX  rs1 index.
- id_rs1_en_i  in  1  uop reads rs1.
- id_rs2_i  in  IDX  rs2 index.
- id_rs2_en_i  in  1  uop reads rs2.
- id_rd_i  in  IDX  rd index.
- id_rd_we_i  in  1  uop writes rd.
- id_ebreak_i  in  1  uop is ebreak.
- ex_ready_i  in  1  EX can accept a uop.
- issue_o  out  1  uop transfers ID→EX this cycle.
- id_stall_o  out  1  hazard blocks issue.
- wb_valid_i  in  1  one uop retires this cycle.
- wb_rd_i  in  IDX  rd of the retiring uop.
- wb_we_i  in  1  retiring uop writes rd.
- redirect_i  in  1  EX resolved a taken branch or jump.
- flush_o  out  1  kill IF/ID contents.
- inflight_o  out  INFL_W  issued-but-not-retired uop count.
- halted_o  out  1  core halted after ebreak.

Behaviour:
- Reset is asynchronous on rst_ni low:
  - all scoreboard counters = 0, inflight = 0, state = RUN, halted_o = 0.
  - Combinational outputs then follow their inputs: issue_o = id_valid_i & ex_ready_i, id_stall_o = 0, flush_o = redirect_i.
  - Reset mid-operation discards all pending state. No retire is expected until new issues occur.
- Hazard (combinational):
  - raw1 = id_rs1_en_i & rs1≠0 & cnt[rs1]≠0; raw2 likewise for rs2.
  - sat = id_rd_we_i & rd≠0 & cnt[rd] = max.
  - full = inflight = 2^INFL_W-1.
  - id_stall_o = id_valid_i & (raw1 | raw2 | sat | full | state≠RUN).
- Issue:
  - issue_o = id_valid_i & ex_ready_i & ~id_stall_o & ~redirect_i.
  - Zero-latency: same cycle as the handshake.
  - A stalled uop stays in ID with its inputs held stable.
- Scoreboard:
  - On issue_o with id_rd_we_i and rd≠0: cnt[rd]++ at the next clock edge.
  - On wb_valid_i with wb_we_i and wb_rd_i≠0: cnt[wb_rd]--.
  - Increment and decrement of the same register in one cycle: net no change.
  - x0 is never tracked.
- In-flight counter: +1 on issue_o, -1 on wb_valid_i; both together means no change.
- Redirect:
  - flush_o = redirect_i, combinational, in every state.
  - Issue is suppressed that cycle.
  - The scoreboard is unchanged: the branch is already in EX, and killed uops never issued.
- FSM:
  - RUN: issue of an ebreak uop (issue_o & id_ebreak_i) → DRAIN.
  - DRAIN: stays until inflight reaches 0. Counting the retire of this cycle, inflight-next = 0 → HALT. No issue in DRAIN.
  - HALT: halted_o = 1. Terminal; exits only through reset.
- Underflow: a retire with cnt[wb_rd] = 0, or with inflight = 0, leaves the counter at 0 and does not wrap.

Optional Feature:
- Macro: PIPE_WB_BYPASS_EN.
- Defined: a source is not a hazard when cnt[rs] = 1 & wb_valid_i & wb_we_i & wb_rd_i = rs in the same cycle, because the value is forwarded from WB.
- Undefined: a RAW stall clears only on the cycle after the counter reaches 0.

Decomposition:
- Shared package liang_pkg holds:
  - hazard_state_e {RUN, DRAIN, HALT};
  - the reg_idx_t typedef;
  - the SB_CNT_W and INFL_W default constants.
- Sub-module pipe_sb_array: counter array, saturation/zero flags, and the inc/dec update. pipe_hazard_ctrl instantiates it and holds the FSM and the in-flight counter.

Test Plan:
1. Issue "add x5" (rd_we) with ex_ready=1, then a uop reading rs1=x5 on the next cycle → id_stall_o=1, issue_o=0. Then wb_valid, wb_rd=5 → the uop issues one cycle later, or in the same cycle with PIPE_WB_BYPASS_EN.
2. Three back-to-back writers to x7 (CNT_W=2), with no retire → cnt[7]=3 and the fourth writer to x7 stalls. One retire of x7 → it issues next cycle.
3. Issue writer to x3 and retire x3 in the same cycle while cnt[3]=1 → cnt[3] stays 1 and a reader of x3 still stalls.
4. Apply redirect_i=1 while id_valid_i=1 and ex_ready_i=1 → flush_o=1, issue_o=0, inflight unchanged.
5. Issue ebreak with inflight=2 → DRAIN and issue blocked. After two retires → HALT next edge and halted_o=1. Later valid uops are never issued.
6. Pulse rst_ni low while in DRAIN with inflight=3 and cnt[9]=2 → halted_o=0, inflight_o=0, and a reader of x9 issues immediately.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared types and default sizes for the decode-stage issue controller
// (pipe_hazard_ctrl) and its scoreboard array (pipe_sb_array).
package liang_pkg;

  // Default architectural register count and derived index width.
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

  // Default per-register pending-writer counter width.
  localparam int SB_CNT_W = 2;

  // Default width of the issued-but-not-retired uop counter.
  localparam int INFL_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // RUN: normal issue. DRAIN: ebreak issued, waiting for the pipe to empty.
  // HALT: terminal until reset.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/pipe_sb_array.sv
// Per-register pending-writer scoreboard. Each architectural register has a
// saturating counter of issued-but-not-retired writers; x0 is never tracked.
// Optional macro PIPE_WB_BYPASS_EN adds "exactly one writer" flags for the
// two source lookups so the parent can forward from writeback.
module pipe_sb_array #(
  parameter int  NUM_REGS = 32,
  parameter int  CNT_W    = liang_pkg::SB_CNT_W,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_en_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic             dec_en_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] rs1_idx_i,
  input  logic [IDX_W-1:0] rs2_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
`ifdef PIPE_WB_BYPASS_EN
  output logic             rs1_one_o,
  output logic             rs2_one_o,
`endif
  output logic             rd_sat_o
);

  import liang_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // Next counter values: inc and dec on the same register cancel, counters
  // neither wrap past max nor underflow below zero, and x0 stays at zero.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (inc_en_i && (inc_idx_i == IDX_W'(i)) &&
          !(dec_en_i && (dec_idx_i == IDX_W'(i)))) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) &&
                   !(inc_en_i && (inc_idx_i == IDX_W'(i)))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
  end

  // Counter storage; reset discards every pending writer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rs1_busy_o = (cnt_q[rs1_idx_i] != '0);
  assign rs2_busy_o = (cnt_q[rs2_idx_i] != '0);
  assign rd_sat_o   = (cnt_q[rd_idx_i] == CNT_MAX);

`ifdef PIPE_WB_BYPASS_EN
  assign rs1_one_o = (cnt_q[rs1_idx_i] == CNT_ONE);
  assign rs2_one_o = (cnt_q[rs2_idx_i] == CNT_ONE);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage issue controller: RAW / saturation / in-flight-full stall
// detection, zero-latency ID->EX issue, branch-redirect flush and the
// ebreak drain-then-halt sequence.
// Optional macro PIPE_WB_BYPASS_EN: a source whose single pending writer is
// retiring this cycle is forwarded from WB and does not stall.
module pipe_hazard_ctrl #(
  parameter int  NUM_REGS = 32,
  parameter int  CNT_W    = liang_pkg::SB_CNT_W,
  parameter int  INFL_W   = liang_pkg::INFL_W,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [IDX_W-1:0]  id_rs1_i,
  input  logic              id_rs1_en_i,
  input  logic [IDX_W-1:0]  id_rs2_i,
  input  logic              id_rs2_en_i,
  input  logic [IDX_W-1:0]  id_rd_i,
  input  logic              id_rd_we_i,
  input  logic              id_ebreak_i,
  input  logic              ex_ready_i,
  output logic              issue_o,
  output logic              id_stall_o,
  input  logic              wb_valid_i,
  input  logic [IDX_W-1:0]  wb_rd_i,
  input  logic              wb_we_i,
  input  logic              redirect_i,
  output logic              flush_o,
  output logic [INFL_W-1:0] inflight_o,
  output logic              halted_o
);

  import liang_pkg::*;

  localparam logic [INFL_W-1:0] INFL_ONE = INFL_W'(1);

  hazard_state_e     state_q, state_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;

  logic rs1_busy, rs2_busy, rd_sat;
  logic raw1, raw2, sat, full;
  logic sb_inc, sb_dec;

  assign sb_inc = issue_o & id_rd_we_i & (id_rd_i != '0);
  assign sb_dec = wb_valid_i & wb_we_i & (wb_rd_i != '0);

`ifdef PIPE_WB_BYPASS_EN
  logic rs1_one, rs2_one;
`endif

  pipe_sb_array #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_en_i   (sb_inc),
    .inc_idx_i  (id_rd_i),
    .dec_en_i   (sb_dec),
    .dec_idx_i  (wb_rd_i),
    .rs1_idx_i  (id_rs1_i),
    .rs2_idx_i  (id_rs2_i),
    .rd_idx_i   (id_rd_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
`ifdef PIPE_WB_BYPASS_EN
    .rs1_one_o  (rs1_one),
    .rs2_one_o  (rs2_one),
`endif
    .rd_sat_o   (rd_sat)
  );

`ifdef PIPE_WB_BYPASS_EN
  // A lone pending writer retiring this cycle is forwarded, not waited for.
  logic fwd1, fwd2;
  assign fwd1 = rs1_one & sb_dec & (wb_rd_i == id_rs1_i);
  assign fwd2 = rs2_one & sb_dec & (wb_rd_i == id_rs2_i);
  assign raw1 = id_rs1_en_i & (id_rs1_i != '0) & rs1_busy & ~fwd1;
  assign raw2 = id_rs2_en_i & (id_rs2_i != '0) & rs2_busy & ~fwd2;
`else
  assign raw1 = id_rs1_en_i & (id_rs1_i != '0) & rs1_busy;
  assign raw2 = id_rs2_en_i & (id_rs2_i != '0) & rs2_busy;
`endif

  assign sat  = id_rd_we_i & (id_rd_i != '0) & rd_sat;
  assign full = (inflight_q == '1);

  assign id_stall_o = id_valid_i & (raw1 | raw2 | sat | full | (state_q != RUN));
  assign issue_o    = id_valid_i & ex_ready_i & ~id_stall_o & ~redirect_i;
  assign flush_o    = redirect_i;
  assign inflight_o = inflight_q;
  assign halted_o   = (state_q == HALT);

  // In-flight count: issue and retire together cancel; never underflows.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_o && !wb_valid_i) begin
      inflight_d = inflight_q + INFL_ONE;
    end else if (!issue_o && wb_valid_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - INFL_ONE;
    end
  end

  // Ebreak sequencing: leave RUN on ebreak issue, halt once the pipe is empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (issue_o && id_ebreak_i) state_d = DRAIN;
      DRAIN:   if (inflight_d == '0) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // State and in-flight registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares mid-cycle.
module tb_pipe_hazard_ctrl;
  import liang_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs1_en, id_rs2_en, id_rd_we, id_ebreak, ex_ready;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       wb_valid, wb_we, redirect;
  logic       issue, stall, flush, halted;
  logic [2:0] inflight;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .id_valid_i  (id_valid),
    .id_rs1_i    (id_rs1),
    .id_rs1_en_i (id_rs1_en),
    .id_rs2_i    (id_rs2),
    .id_rs2_en_i (id_rs2_en),
    .id_rd_i     (id_rd),
    .id_rd_we_i  (id_rd_we),
    .id_ebreak_i (id_ebreak),
    .ex_ready_i  (ex_ready),
    .issue_o     (issue),
    .id_stall_o  (stall),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .wb_we_i     (wb_we),
    .redirect_i  (redirect),
    .flush_o     (flush),
    .inflight_o  (inflight),
    .halted_o    (halted)
  );

  typedef struct packed {
    logic       issue;
    logic       stall;
    logic       flush;
    logic [2:0] infl;
    logic       halt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_en = 0; id_rs2 = 0; id_rs2_en = 0;
    id_rd = 0; id_rd_we = 0; id_ebreak = 0; ex_ready = 0;
    wb_valid = 0; wb_rd = 0; wb_we = 0; redirect = 0;
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic uop(input logic [4:0] rs1, input logic rs1_en,
                     input logic [4:0] rs2, input logic rs2_en,
                     input logic [4:0] rd, input logic rd_we);
    id_valid = 1; ex_ready = 1;
    id_rs1 = rs1; id_rs1_en = rs1_en; id_rs2 = rs2; id_rs2_en = rs2_en;
    id_rd = rd; id_rd_we = rd_we;
  endtask

  task automatic wb(input logic [4:0] rd, input logic we);
    wb_valid = 1; wb_rd = rd; wb_we = we;
  endtask

  task automatic exp(input string nm, input logic e_issue, input logic e_stall,
                     input logic e_flush, input logic [2:0] e_infl, input logic e_halt);
    exp_t e;
    e.issue = e_issue; e.stall = e_stall; e.flush = e_flush;
    e.infl = e_infl; e.halt = e_halt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input string field,
                     input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0d required %0d", nm, field, act, req);
    end
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "issue", {2'b0, issue}, {2'b0, e.issue});
        chk(nm, "stall", {2'b0, stall}, {2'b0, e.stall});
        chk(nm, "flush", {2'b0, flush}, {2'b0, e.flush});
        chk(nm, "inflight", inflight, e.infl);
        chk(nm, "halted", {2'b0, halted}, {2'b0, e.halt});
        $display("txn %-12s issue=%0b stall=%0b flush=%0b inflight=%0d halted=%0b",
                 nm, issue, stall, flush, inflight, halted);
      end
    end
  end

  initial begin
    idle();
    // Reset state: combinational outputs follow inputs
    tick(); uop(0,0,0,0,0,0);              exp("rst_issue", 1,0,0,0,0);
    tick(); uop(0,0,0,0,0,0); redirect=1;  exp("rst_flush", 0,0,1,0,0);
    tick(); rst_n = 1;                     exp("rst_rel",   0,0,0,0,0);

    // 1: RAW on x5
    tick(); uop(0,0,0,0,5,1);              exp("t1_wr5",    1,0,0,0,0);
    tick(); uop(5,1,0,0,6,1);              exp("t1_raw",    0,1,0,1,0);
`ifdef PIPE_WB_BYPASS_EN
    tick(); uop(5,1,0,0,6,1); wb(5,1);     exp("t1_byp",    1,0,0,1,0);
`else
    tick(); uop(5,1,0,0,6,1); wb(5,1);     exp("t1_wbraw",  0,1,0,1,0);
    tick(); uop(5,1,0,0,6,1);              exp("t1_go",     1,0,0,0,0);
`endif
    tick(); wb(6,1);                       exp("t1_ret6",   0,0,0,1,0);

    // 2: saturation of x7
    tick(); uop(0,0,0,0,7,1);              exp("t2_w1",     1,0,0,0,0);
    tick(); uop(0,0,0,0,7,1);              exp("t2_w2",     1,0,0,1,0);
    tick(); uop(0,0,0,0,7,1);              exp("t2_w3",     1,0,0,2,0);
    tick(); uop(0,0,0,0,7,1);              exp("t2_sat",    0,1,0,3,0);
    tick(); uop(0,0,0,0,7,1); wb(7,1);     exp("t2_satwb",  0,1,0,3,0);
    tick(); uop(0,0,0,0,7,1);              exp("t2_w4",     1,0,0,2,0);
    for (int i = 0; i < 3; i++) begin
      tick(); wb(7,1);                     exp("t2_ret7",   0,0,0,3'(3-i),0);
    end

    // In-flight full, with x0 writers (x0 is never tracked so never saturates)
    for (int i = 0; i < 7; i++) begin
      tick(); uop(0,0,0,0,0,1);            exp("full_fill", 1,0,0,3'(i),0);
    end
    tick(); uop(0,0,0,0,0,1);              exp("full_stl",  0,1,0,7,0);
    for (int i = 0; i < 7; i++) begin
      tick(); wb(0,1);                     exp("full_drn",  0,0,0,3'(7-i),0);
    end

    // 3: inc and dec of x3 in the same cycle
    tick(); uop(0,0,0,0,3,1);              exp("t3_wr3",    1,0,0,0,0);
    tick(); uop(0,0,0,0,3,1); wb(3,1);     exp("t3_incdec", 1,0,0,1,0);
    tick(); uop(0,0,3,1,0,0);              exp("t3_raw",    0,1,0,1,0);
    tick(); wb(3,1);                       exp("t3_ret3",   0,0,0,1,0);

    // Underflow: retire with cnt[3]=0 and inflight=0
    tick(); wb(3,1);                       exp("uf_ret",    0,0,0,0,0);
    tick(); uop(0,0,3,1,0,0);              exp("uf_rd3",    1,0,0,0,0);
    tick(); wb(0,0);                       exp("uf_ret2",   0,0,0,1,0);

    // 4: redirect
    tick(); uop(0,0,0,0,0,0); redirect=1;  exp("t4_redir",  0,0,1,0,0);
    tick();                                exp("t4_after",  0,0,0,0,0);

    // 5: ebreak drain and halt
    tick(); uop(0,0,0,0,0,0);              exp("t5_pre",    1,0,0,0,0);
    tick(); uop(0,0,0,0,0,0); id_ebreak=1; exp("t5_ebrk",   1,0,0,1,0);
    tick(); uop(0,0,0,0,0,0);              exp("t5_drain",  0,1,0,2,0);
    tick(); uop(0,0,0,0,0,0); wb(0,0);     exp("t5_ret1",   0,1,0,2,0);
    tick(); uop(0,0,0,0,0,0); wb(0,0);     exp("t5_ret2",   0,1,0,1,0);
    tick(); uop(0,0,0,0,0,0);              exp("t5_halt",   0,1,0,0,1);
    tick(); uop(0,0,0,0,0,0); redirect=1;  exp("t5_hflush", 0,1,1,0,1);

    // 6: reset during DRAIN with pending x9 writers
    tick(); rst_n = 0;                     exp("t6_rst",    0,0,0,0,0);
    tick(); rst_n = 1;                     exp("t6_rel",    0,0,0,0,0);
    tick(); uop(0,0,0,0,9,1);              exp("t6_w9a",    1,0,0,0,0);
    tick(); uop(0,0,0,0,9,1);              exp("t6_w9b",    1,0,0,1,0);
    tick(); uop(0,0,0,0,0,0); id_ebreak=1; exp("t6_ebrk",   1,0,0,2,0);
    tick(); uop(9,1,0,0,0,0);              exp("t6_raw9",   0,1,0,3,0);
    tick(); rst_n = 0; uop(9,1,0,0,0,0);   exp("t6_rstrd",  1,0,0,0,0);
    tick(); rst_n = 1; uop(9,1,0,0,0,0);   exp("t6_rd9",    1,0,0,0,0);
    tick();                                exp("t6_end",    0,0,0,1,0);

    // Let the monitor consume the last expectations (bounded)
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
